// File: rtl/spi_ram_responder_if.sv
// SPI pin and backing-store bus bundle for spi_ram_responder.
// The master modport is the environment side; the slave modport is the responder.
interface spi_ram_responder_if;
   logic        spi_cs_n;
   logic        spi_sck;
   logic        spi_mosi;
   logic        spi_miso;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [7:0]  mem_rdata;
   logic        active;
   logic        cmd_err;

   modport slave (
      input  spi_cs_n, spi_sck, spi_mosi, mem_rdata,
      output spi_miso, mem_addr, mem_wdata, mem_we, mem_re, active, cmd_err
   );

   modport master (
      output spi_cs_n, spi_sck, spi_mosi, mem_rdata,
      input  spi_miso, mem_addr, mem_wdata, mem_we, mem_re, active, cmd_err
   );
endinterface

// File: rtl/spi_ram_responder.sv
// SPI mode-0 responder bridging READ (0x03) / WRITE (0x02) commands to a byte-wide store.
// Optional macro SPI_RESP_RDSR_EN adds RDSR (0x05), which returns 0x40 with no address phase.
module spi_ram_responder (
   input  logic               clk,
   input  logic               rst_n,
   spi_ram_responder_if.slave bus
);
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_READ   = 3'd3,
      ST_WRITE  = 3'd4,
      ST_IGNORE = 3'd5
   } state_e;

   localparam logic [7:0] CMD_READ   = 8'h03;
   localparam logic [7:0] CMD_WRITE  = 8'h02;
   localparam logic [7:0] CMD_RDSR   = 8'h05;
   localparam logic [7:0] RDSR_VALUE = 8'h40;

   logic [1:0]  cs_sync_q;
   logic [1:0]  sck_sync_q;
   logic [1:0]  mosi_sync_q;
   logic        cs_prev_q;
   logic        sck_prev_q;

   state_e      state_q;
   logic [3:0]  bit_cnt_q;
   logic [15:0] shift_q;
   logic [15:0] addr_q;
   logic [7:0]  tx_q;
   logic        is_write_q;
   logic        rdsr_q;
   logic        rd_cap_q;
   logic        miso_q;
   logic [15:0] mem_addr_q;
   logic [7:0]  mem_wdata_q;
   logic        mem_we_q;
   logic        mem_re_q;
   logic        active_q;
   logic        cmd_err_q;

   logic        sck_rise_d;
   logic        sck_fall_d;
   logic        cs_fall_d;
   logic        cs_rise_d;
   logic [15:0] shift_d;
   logic [15:0] addr_inc_d;

   assign sck_rise_d = sck_sync_q[1] & ~sck_prev_q;
   assign sck_fall_d = ~sck_sync_q[1] & sck_prev_q;
   assign cs_fall_d  = ~cs_sync_q[1] & cs_prev_q;
   assign cs_rise_d  = cs_sync_q[1] & ~cs_prev_q;
   assign shift_d    = {shift_q[14:0], mosi_sync_q[1]};
   assign addr_inc_d = addr_q + 16'd1;

   assign bus.spi_miso  = miso_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_re    = mem_re_q;
   assign bus.active    = active_q;
   assign bus.cmd_err   = cmd_err_q;

   // Two-flop synchronizers for the asynchronous SPI pins plus edge-detect history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_sync_q   <= 2'b11;
         sck_sync_q  <= 2'b00;
         mosi_sync_q <= 2'b00;
         cs_prev_q   <= 1'b1;
         sck_prev_q  <= 1'b0;
      end else begin
         cs_sync_q   <= {cs_sync_q[0], bus.spi_cs_n};
         sck_sync_q  <= {sck_sync_q[0], bus.spi_sck};
         mosi_sync_q <= {mosi_sync_q[0], bus.spi_mosi};
         cs_prev_q   <= cs_sync_q[1];
         sck_prev_q  <= sck_sync_q[1];
      end
   end

   // Transaction FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 4'd0;
         shift_q     <= 16'h0000;
         addr_q      <= 16'h0000;
         tx_q        <= 8'h00;
         is_write_q  <= 1'b0;
         rdsr_q      <= 1'b0;
         rd_cap_q    <= 1'b0;
         miso_q      <= 1'b0;
         mem_addr_q  <= 16'h0000;
         mem_wdata_q <= 8'h00;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         active_q    <= 1'b0;
         cmd_err_q   <= 1'b0;
      end else begin
         mem_we_q  <= 1'b0;
         mem_re_q  <= 1'b0;
         cmd_err_q <= 1'b0;
         rd_cap_q  <= mem_re_q;
         active_q  <= ~cs_sync_q[1];

         if (cs_rise_d) begin
            // Deselect wins over any partial byte: nothing further reaches the store.
            state_q  <= ST_IDLE;
            miso_q   <= 1'b0;
            rdsr_q   <= 1'b0;
            rd_cap_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (cs_fall_d) begin
                     state_q   <= ST_CMD;
                     bit_cnt_q <= 4'd0;
                     miso_q    <= 1'b0;
                  end
               end
               ST_CMD: begin
                  if (sck_rise_d) begin
                     shift_q   <= shift_d;
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     if (bit_cnt_q == 4'd7) begin
                        bit_cnt_q <= 4'd0;
                        case (shift_d[7:0])
                           CMD_READ: begin
                              state_q    <= ST_ADDR;
                              is_write_q <= 1'b0;
                           end
                           CMD_WRITE: begin
                              state_q    <= ST_ADDR;
                              is_write_q <= 1'b1;
                           end
`ifdef SPI_RESP_RDSR_EN
                           CMD_RDSR: begin
                              state_q <= ST_READ;
                              rdsr_q  <= 1'b1;
                              tx_q    <= RDSR_VALUE;
                           end
`endif
                           default: begin
                              state_q   <= ST_IGNORE;
                              cmd_err_q <= 1'b1;
                           end
                        endcase
                     end
                  end
               end
               ST_ADDR: begin
                  if (sck_rise_d) begin
                     shift_q   <= shift_d;
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     if (bit_cnt_q == 4'd15) begin
                        addr_q <= shift_d;
                        if (is_write_q) begin
                           state_q <= ST_WRITE;
                        end else begin
                           state_q    <= ST_READ;
                           mem_re_q   <= 1'b1;
                           mem_addr_q <= shift_d;
                        end
                     end
                  end
               end
               ST_READ: begin
                  // Store data lands the clk after mem_re; falls come at least 4 clk later.
                  if (rd_cap_q && !rdsr_q) begin
                     tx_q <= bus.mem_rdata;
                  end else if (sck_fall_d) begin
                     miso_q <= tx_q[7];
                     tx_q   <= {tx_q[6:0], 1'b0};
                  end
                  if (sck_rise_d) begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     if (bit_cnt_q == 4'd7) begin
                        bit_cnt_q <= 4'd0;
                        if (rdsr_q) begin
                           tx_q <= RDSR_VALUE;
                        end else begin
                           addr_q     <= addr_inc_d;
                           mem_re_q   <= 1'b1;
                           mem_addr_q <= addr_inc_d;
                        end
                     end
                  end
               end
               ST_WRITE: begin
                  if (sck_rise_d) begin
                     shift_q   <= shift_d;
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     if (bit_cnt_q == 4'd7) begin
                        bit_cnt_q   <= 4'd0;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= shift_d[7:0];
                        addr_q      <= addr_inc_d;
                     end
                  end
               end
               ST_IGNORE: begin
                  miso_q <= 1'b0;
               end
               default: begin
                  state_q <= ST_IDLE;
                  miso_q  <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed scoreboard bench for spi_ram_responder: store strobes and MISO bytes
// are queued as expectations when stimulus is driven and popped when observed.
module tb_spi_ram_responder;
   logic clk = 1'b0;
   logic rst_n;

   spi_ram_responder_if bus ();

   spi_ram_responder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   logic [7:0]  mem [0:65535];
   logic [23:0] exp_wr_q [$];
   logic [15:0] exp_rd_q [$];
   logic [7:0]  exp_miso_q [$];
   logic [23:0] exp_wr;
   logic [15:0] exp_rd;
   int          compared = 0;
   int          mismatched = 0;
   int          cmd_err_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Backing store: registered read, data valid the clk after mem_re.
   always @(posedge clk) begin
      if (bus.mem_re === 1'b1) bus.mem_rdata <= mem[bus.mem_addr];
   end

   // Strobe monitor and scoreboard pop, sampled on the inactive edge.
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1 || bus.mem_re === 1'b1)
         check("we_re_exclusive", {31'd0, bus.mem_we & bus.mem_re}, 32'd0);
      if (bus.mem_we === 1'b1) begin
         check("we_expected", {31'd0, exp_wr_q.size() > 0}, 32'd1);
         if (exp_wr_q.size() > 0) begin
            exp_wr = exp_wr_q.pop_front();
            check("we_addr_data", {8'h00, bus.mem_addr, bus.mem_wdata}, {8'h00, exp_wr});
         end
      end
      if (bus.mem_re === 1'b1) begin
         check("re_expected", {31'd0, exp_rd_q.size() > 0}, 32'd1);
         if (exp_rd_q.size() > 0) begin
            exp_rd = exp_rd_q.pop_front();
            check("re_addr", {16'h0000, bus.mem_addr}, {16'h0000, exp_rd});
         end
      end
      if (bus.cmd_err === 1'b1) cmd_err_cnt++;
   end

   task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         bus.spi_mosi = tx[i];
         #60;
         rx[i] = bus.spi_miso;
         bus.spi_sck = 1'b1;
         #60;
         bus.spi_sck = 1'b0;
      end
   endtask

   task automatic send(input logic [7:0] tx);
      logic [7:0] rx;
      spi_xfer(tx, 8, rx);
   endtask

   task automatic xfer_expect(input string tag, input logic [7:0] tx);
      logic [7:0] rx;
      logic [7:0] e;
      spi_xfer(tx, 8, rx);
      check({tag, "_queued"}, {31'd0, exp_miso_q.size() > 0}, 32'd1);
      if (exp_miso_q.size() > 0) begin
         e = exp_miso_q.pop_front();
         check(tag, {24'd0, rx}, {24'd0, e});
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miso"},    {31'd0, bus.spi_miso}, 32'd0);
      check({tag, "_we"},      {31'd0, bus.mem_we},   32'd0);
      check({tag, "_re"},      {31'd0, bus.mem_re},   32'd0);
      check({tag, "_active"},  {31'd0, bus.active},   32'd0);
      check({tag, "_cmd_err"}, {31'd0, bus.cmd_err},  32'd0);
      check({tag, "_addr"},    {16'd0, bus.mem_addr}, 32'd0);
      check({tag, "_wdata"},   {24'd0, bus.mem_wdata}, 32'd0);
   endtask

   task automatic cs_low();
      bus.spi_cs_n = 1'b0;
      #60;
   endtask

   task automatic cs_high();
      #60;
      bus.spi_cs_n = 1'b1;
      #60;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int         err_before;
      logic [7:0] rx;

      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
      mem[16'h1234] = 8'hA5;
      mem[16'h1235] = 8'h5A;
      mem[16'h0008] = 8'h3C;
      mem[16'h0009] = 8'hC3;

      rst_n        = 1'b0;
      bus.spi_cs_n = 1'b1;
      bus.spi_sck  = 1'b0;
      bus.spi_mosi = 1'b0;
      #47;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      #60;

      // Read at 0x1234 with a second sequential byte.
      cs_low();
      check("active_selected", {31'd0, bus.active}, 32'd1);
      send(8'h03);
      send(8'h12);
      exp_rd_q.push_back(16'h1234);
      send(8'h34);
      exp_rd_q.push_back(16'h1235);
      exp_miso_q.push_back(8'hA5);
      xfer_expect("read_1234", 8'h00);
      exp_rd_q.push_back(16'h1236);
      exp_miso_q.push_back(8'h5A);
      xfer_expect("read_1235", 8'h00);
      cs_high();
      check("read_active_off", {31'd0, bus.active},   32'd0);
      check("read_miso_off",   {31'd0, bus.spi_miso}, 32'd0);

      // Sequential write wrapping 0xFFFF -> 0x0000.
      cs_low();
      send(8'h02);
      send(8'hFF);
      send(8'hFF);
      exp_wr_q.push_back({16'hFFFF, 8'h11});
      send(8'h11);
      exp_wr_q.push_back({16'h0000, 8'h22});
      send(8'h22);
      cs_high();

      // Abort during a partial data byte: no write may follow.
      cs_low();
      send(8'h02);
      send(8'h00);
      send(8'h10);
      spi_xfer(8'hF8, 5, rx);
      cs_high();
      check("abort_active", {31'd0, bus.active},   32'd0);
      check("abort_miso",   {31'd0, bus.spi_miso}, 32'd0);

      // Unsupported command, then bytes that must be ignored.
      err_before = cmd_err_cnt;
      cs_low();
      exp_miso_q.push_back(8'h00);
      xfer_expect("badcmd_miso0", 8'h9C);
      exp_miso_q.push_back(8'h00);
      xfer_expect("badcmd_miso1", 8'h03);
      exp_miso_q.push_back(8'h00);
      xfer_expect("badcmd_miso2", 8'h00);
      cs_high();
      check("badcmd_err_pulses", 32'(cmd_err_cnt - err_before), 32'd1);

      // Status read.
      err_before = cmd_err_cnt;
      cs_low();
      send(8'h05);
`ifdef SPI_RESP_RDSR_EN
      exp_miso_q.push_back(8'h40);
      exp_miso_q.push_back(8'h40);
      xfer_expect("rdsr_byte0", 8'h00);
      xfer_expect("rdsr_byte1", 8'h00);
      cs_high();
      check("rdsr_err_pulses", 32'(cmd_err_cnt - err_before), 32'd0);
`else
      exp_miso_q.push_back(8'h00);
      exp_miso_q.push_back(8'h00);
      xfer_expect("rdsr_off_byte0", 8'h00);
      xfer_expect("rdsr_off_byte1", 8'h00);
      cs_high();
      check("rdsr_off_err_pulses", 32'(cmd_err_cnt - err_before), 32'd1);
`endif

      // Reset in the middle of a read, then a fresh read at 0x0009.
      cs_low();
      send(8'h03);
      send(8'h00);
      exp_rd_q.push_back(16'h0008);
      send(8'h08);
      spi_xfer(8'h00, 3, rx);
      rst_n = 1'b0;
      #30;
      check_reset_outputs("midreset");
      bus.spi_cs_n = 1'b1;
      #30;
      rst_n = 1'b1;
      #60;
      cs_low();
      send(8'h03);
      send(8'h00);
      exp_rd_q.push_back(16'h0009);
      send(8'h09);
      exp_rd_q.push_back(16'h000A);
      exp_miso_q.push_back(8'hC3);
      xfer_expect("read_0009", 8'h00);
      cs_high();
      #60;

      check("wr_queue_drained",   32'(exp_wr_q.size()),   32'd0);
      check("rd_queue_drained",   32'(exp_rd_q.size()),   32'd0);
      check("miso_queue_drained", 32'(exp_miso_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
